// File: rtl/poly_ram_line_packer_if.sv
// Command, coefficient-stream and RAM-write signals of the polynomial RAM line packer.
// The packer attaches to the slave modport; the command/stream source uses master.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

interface poly_ram_line_packer_if #(
  parameter int COUNT_W = `ADDR_WIDTH + $clog2(`LINE_SIZE) + 1
);
  logic                              start;
  logic [`ADDR_WIDTH-1:0]            base_addr;
  logic [COUNT_W-1:0]                coeff_num;
  logic                              busy;
  logic                              done;
  logic                              in_valid;
  logic [`BIT_WIDTH-1:0]             in_data;
  logic                              in_ready;
  logic [`LINE_SIZE-1:0]             ram_we;
  logic [`ADDR_WIDTH-1:0]            ram_addr;
  logic [`BIT_WIDTH*`LINE_SIZE-1:0]  ram_din;

  modport master (
    output start, base_addr, coeff_num, in_valid, in_data,
    input  busy, done, in_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  start, base_addr, coeff_num, in_valid, in_data,
    output busy, done, in_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/poly_ram_line_packer.sv
// Packs a valid/ready coefficient stream into LINE_SIZE-lane RAM lines and issues one
// lane-enabled write per completed line, including a trailing partial line.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module poly_ram_line_packer #(
  parameter int COUNT_W = `ADDR_WIDTH + $clog2(`LINE_SIZE) + 1
) (
  input logic                    clk,
  input logic                    rst,
  poly_ram_line_packer_if.slave  bus
);
  localparam int AW     = `ADDR_WIDTH;
  localparam int LS     = `LINE_SIZE;
  localparam int BW     = `BIT_WIDTH;
  localparam int LANE_W = (LS > 1) ? $clog2(LS) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state, nextState;
  logic [AW-1:0]       baseAddr, lineIdx;
  logic [COUNT_W-1:0]  remaining;
  logic [LANE_W-1:0]   laneIdx;
  logic [BW*LS-1:0]    lineBuf, mergedDin;
  logic [LS-1:0]       lineWe, mergedWe;
  logic                handshake, lastCoeff, closeLine;

  assign handshake = (state == FILL) && bus.in_valid;
  assign lastCoeff = (remaining == COUNT_W'(1));
  assign closeLine = handshake && ((laneIdx == LANE_W'(LS - 1)) || lastCoeff);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block infers a latch.
    nextState = state;
    unique case (state)
      IDLE:    if (bus.start) nextState = (bus.coeff_num != '0) ? FILL : DONE;
      FILL:    if (handshake && lastCoeff) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // in_ready depends on state alone, so upstream sees no path from in_valid.
  always_comb begin
    bus.in_ready = (state == FILL);
  end

  // The incoming coefficient dropped into its lane of the line under construction.
  always_comb begin
    mergedDin = lineBuf;
    mergedWe  = lineWe;
    for (int i = 0; i < LS; i++) begin
      if (laneIdx == LANE_W'(i)) begin
        mergedDin[i*BW +: BW] = bus.in_data;
        mergedWe[i]           = 1'b1;
      end
    end
  end

  // NOTE: line buffer is a register bank, not a RAM, so clearing it on reset is cheap
  // and guarantees a discarded partial line can never leak into a later write.
  always_ff @(posedge clk) begin
    if (rst) begin
      baseAddr     <= '0;
      remaining    <= '0;
      laneIdx      <= '0;
      lineIdx      <= '0;
      lineBuf      <= '0;
      lineWe       <= '0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.ram_we   <= '0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
    end else begin
      bus.busy   <= (nextState != IDLE);
      bus.done   <= (nextState == DONE);
      bus.ram_we <= '0;
      if (state == IDLE && bus.start) begin
        baseAddr  <= bus.base_addr;
        remaining <= bus.coeff_num;
        laneIdx   <= '0;
        lineIdx   <= '0;
        lineBuf   <= '0;
        lineWe    <= '0;
      end else if (handshake) begin
        remaining <= remaining - COUNT_W'(1);
        if (closeLine) begin
          bus.ram_din  <= mergedDin;
          bus.ram_we   <= mergedWe;
          bus.ram_addr <= baseAddr + lineIdx;
          lineIdx      <= lineIdx + AW'(1);
          laneIdx      <= '0;
          lineBuf      <= '0;
          lineWe       <= '0;
        end else begin
          lineBuf <= mergedDin;
          lineWe  <= mergedWe;
          laneIdx <= laneIdx + LANE_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_poly_ram_line_packer.sv
// Self-checking bench for poly_ram_line_packer: expected RAM writes are queued when a
// load is driven and popped by a write monitor that also fills a RAM image.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 4
`endif
`ifndef LINE_SIZE
`define LINE_SIZE 4
`endif
`ifndef BIT_WIDTH
`define BIT_WIDTH 16
`endif

module tb_poly_ram_line_packer;
  localparam int AW = `ADDR_WIDTH;
  localparam int LS = `LINE_SIZE;
  localparam int BW = `BIT_WIDTH;
  localparam int CW = AW + $clog2(LS) + 1;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic [LS-1:0]    we;
    logic [AW-1:0]    addr;
    logic [BW*LS-1:0] din;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  wr_t              expQ[$];
  logic [BW-1:0]    loadData[$];
  logic [BW*LS-1:0] ramImg [DEPTH];
  logic [BW*LS-1:0] expImg [DEPTH];

  poly_ram_line_packer_if #(.COUNT_W(CW)) bus ();

  poly_ram_line_packer #(.COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor: every non-zero ram_we must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t got, exp;
    if (!rst && bus.ram_we !== '0) begin
      got = '{we: bus.ram_we, addr: bus.ram_addr, din: bus.ram_din};
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got we=%h addr=%h din=%h required none",
                 got.we, got.addr, got.din);
      end else begin
        exp = expQ.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL ram_write got we=%h addr=%h din=%h required we=%h addr=%h din=%h",
                   got.we, got.addr, got.din, exp.we, exp.addr, exp.din);
        end
      end
      for (int l = 0; l < LS; l++)
        if (got.we[l]) ramImg[got.addr][l*BW +: BW] = got.din[l*BW +: BW];
    end
  end

  task automatic push_expected(input logic [AW-1:0] base, input int n);
    int  lines;
    wr_t e;
    lines = (n + LS - 1) / LS;
    for (int k = 0; k < lines; k++) begin
      e.we   = '0;
      e.din  = '0;
      e.addr = base + AW'(k);
      for (int l = 0; l < LS; l++) begin
        if (k*LS + l < n) begin
          e.we[l]           = 1'b1;
          e.din[l*BW +: BW] = loadData[k*LS + l];
          expImg[e.addr][l*BW +: BW] = loadData[k*LS + l];
        end
      end
      expQ.push_back(e);
    end
  endtask

  task automatic fill_ramp(input int n);
    loadData.delete();
    for (int i = 1; i <= n; i++) loadData.push_back(BW'(i));
  endtask

  // Drives one load. stallMode: 0 = in_valid held high, 1 = 1,0,0 pattern, 2 = random.
  task automatic run_load(input logic [AW-1:0] base, input int n, input int stallMode,
                          input bit injectStart, input string name);
    int   idx, cyc, budget;
    logic v, rdy;
    push_expected(base, n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = base; bus.coeff_num = CW'(n);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (n != 0) begin
      checks++;
      if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_start got in_ready=%b busy=%b required 1 1", name, bus.in_ready, bus.busy);
      end
    end
    idx = 0; cyc = 0; budget = 4*n + 20;
    while (idx < n && cyc < budget) begin
      case (stallMode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bus.in_valid = v;
      bus.in_data  = v ? loadData[idx] : BW'(16'hDEAD);
      if (injectStart && cyc == 1) begin
        bus.start = 1'b1; bus.base_addr = base + AW'(5); bus.coeff_num = CW'(3);
      end else begin
        bus.start = 1'b0;
      end
      rdy = bus.in_ready;
      @(posedge clk); #1;
      if (v && rdy) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (idx < n) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d handshakes required %0d", name, idx, n);
    end
    if (stallMode == 0 && !injectStart) begin
      checks++;
      if (cyc != n) begin
        errors++;
        $display("FAIL %s_throughput got %0d cycles required %0d", name, cyc, n);
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_done got done=%b busy=%b in_ready=%b required 1 1 0",
               name, bus.done, bus.busy, bus.in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got done=%b busy=%b required 0 0", name, bus.done, bus.busy);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got %0d writes outstanding required 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if ({bus.busy, bus.done, bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_din} !== '0) begin
      errors++;
      $display("FAIL %s got busy=%b done=%b in_ready=%b we=%h addr=%h din=%h required all 0",
               name, bus.busy, bus.done, bus.in_ready, bus.ram_we, bus.ram_addr, bus.ram_din);
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.base_addr = '0; bus.coeff_num = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_outputs_zero("reset_values");
  endtask

  task automatic test_full_lines;
    fill_ramp(8);
    run_load(AW'(8'h10), 8, 0, 1'b0, "full_lines");
    checks++;
    if (bus.ram_we !== '0 || bus.ram_addr !== AW'(8'h11)) begin
      errors++;
      $display("FAIL full_lines_hold got we=%h addr=%h required 0 %h",
               bus.ram_we, bus.ram_addr, AW'(8'h11));
    end
  endtask

  task automatic test_partial_tail;
    fill_ramp(6);
    run_load(AW'(3), 6, 0, 1'b0, "partial_tail");
  endtask

  task automatic test_stall_wrap;
    fill_ramp(8);
    run_load(AW'(DEPTH - 1), 8, 1, 1'b0, "stall_wrap");
  endtask

  task automatic test_zero_and_ignored_start;
    loadData.delete();
    run_load(AW'(7), 0, 0, 1'b0, "zero_count");
    fill_ramp(7);
    run_load(AW'(2), 7, 0, 1'b1, "ignored_start");
  endtask

  task automatic test_reset_mid_op;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.base_addr = AW'(8'h10); bus.coeff_num = CW'(4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      bus.in_valid = 1'b1; bus.in_data = BW'(i);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_outputs_zero("reset_mid_op");
    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset_mid_op_quiet");
    fill_ramp(4);
    run_load(AW'(8'h10), 4, 0, 1'b0, "after_reset");
  endtask

  task automatic test_random_loads;
    int n;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 64);
      loadData.delete();
      for (int i = 0; i < n; i++) loadData.push_back(BW'($urandom));
      run_load(AW'($urandom), n, 2, 1'b0, "random_load");
    end
    for (int a = 0; a < DEPTH; a++) begin
      checks++;
      if (ramImg[a] !== expImg[a]) begin
        errors++;
        $display("FAIL ram_image[%0d] got %h required %h", a, ramImg[a], expImg[a]);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      ramImg[a] = '0;
      expImg[a] = '0;
    end
    test_reset();
    test_full_lines();
    test_partial_tail();
    test_stall_wrap();
    test_zero_and_ignored_start();
    test_reset_mid_op();
    test_random_loads();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/poly_ram_line_packer.md
# poly_ram_line_packer

Upstream write stage for the dual-port byte-enabled polynomial RAM. It accepts a stream of single coefficients over a valid/ready handshake and packs them into `LINE_SIZE`-lane lines. Each completed line is issued as one RAM write at `base_addr + line_idx`. A trailing partial line is written with only its filled lanes enabled. The block drives port A or port B of the RAM directly and sustains one coefficient per cycle.

## Interface
- `COUNT_W`, default `` `ADDR_WIDTH + $clog2(`LINE_SIZE) + 1 ``: width of the coefficient count.
- `clk`  in  1  the single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle command pulse; honoured only in IDLE.
- `base_addr`  in  `` `ADDR_WIDTH ``  first RAM line address; latched on accepted `start`.
- `coeff_num`  in  `COUNT_W`  number of coefficients to load; latched on accepted `start`.
- `busy`  out  1  high from the cycle after an accepted non-zero `start` through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `in_valid`  in  1  coefficient valid.
- `in_data`  in  `` `BIT_WIDTH ``  coefficient.
- `in_ready`  out  1  high exactly while in FILL.
- `ram_we`  out  `` `LINE_SIZE ``  per-lane write enable to the RAM.
- `ram_addr`  out  `` `ADDR_WIDTH ``  RAM line address.
- `ram_din`  out  `` `BIT_WIDTH*`LINE_SIZE ``  packed line; lane i occupies bits `[i*BIT_WIDTH +: BIT_WIDTH]`.

## Operation
- **States.** IDLE, FILL, DONE.
- **IDLE.**
  - `start` with `coeff_num != 0`: latch `base_addr` and `coeff_num`; clear lane index, line index and line buffer; go to FILL.
  - `start` with `coeff_num == 0`: go to DONE. `busy` pulses for that one cycle; no RAM write occurs.
- **FILL.**
  - `in_ready = 1`; a handshake is `in_valid & in_ready`.
  - Each handshake stores `in_data` into lane `lane_idx`, increments `lane_idx` and decrements `remaining`.
  - **Line close.** A handshake with `lane_idx == LINE_SIZE-1` or `remaining == 1` closes the line. On the next cycle the output register presents:
    - `ram_din`: the buffer merged with the closing coefficient; unfilled lanes are 0.
    - `ram_we`: 1 for each filled lane.
    - `ram_addr`: `base_addr + line_idx`, modulo 2^`ADDR_WIDTH`.
  - After a close, `line_idx` increments and `lane_idx` and the buffer clear in the same edge. The next line can accept a coefficient in the very next cycle, so there are no bubbles.
  - The handshake with `remaining == 1` moves the FSM to DONE.
- **DONE.**
  - `done = 1` and `busy = 1` for one cycle; `in_ready = 0`.
  - This cycle coincides with the final RAM write.
  - The FSM then returns to IDLE.
- **Write enables.** `ram_we` is all-zero in every cycle that does not follow a line close. `ram_din` and `ram_addr` hold their last values when `ram_we == 0`.
- **Ignored start.** `start` during FILL or DONE is ignored and does not alter the latched values.
- **Address wrap.** If `coeff_num` exceeds the RAM capacity (2^`ADDR_WIDTH` × `LINE_SIZE`), `ram_addr` wraps and earlier lines are overwritten.
- **Input stalls.** `in_valid = 0` stalls FILL indefinitely with all state held.
- **Reset.** `rst` high at any edge, including mid-FILL, forces the following:
  - FSM to IDLE.
  - All counters and the line buffer to 0.
  - Outputs to 0 after that edge.
  - Any partially filled line is discarded and never written.

## Timing
- **Reset values.** `busy` 0, `done` 0, `in_ready` 0, `ram_we` 0, `ram_addr` 0, `ram_din` 0.
- **Start latency.** `start` at edge n puts the FSM in FILL; `in_ready = 1` in cycle n+1. The first handshake can occur in cycle n+1.
- **Write latency.** A line-closing handshake in cycle t gives `ram_we != 0` in cycle t+1. The RAM samples the write at edge t+2.
- **Completion.** The last handshake in cycle t gives `done = 1` in cycle t+1. `busy = 0` and a new `start` can be accepted in cycle t+2.
- **Throughput.** With `in_valid` held high, N coefficients complete in N+1 cycles after FILL entry.
- **Output decoding.** `in_ready` is decoded from state only; there is no combinational path from `in_valid`.
- **Registered outputs.** All other outputs are registered.

## Test plan
Values below are for a `LINE_SIZE=4` build.
- **Full lines, back-to-back.** `start`, `base_addr=0x10`, `coeff_num=8`, `in_data` 1..8 with `in_valid` held high. Required: `ram_we=4'hF` at address 0x10 with lanes {1,2,3,4}, then `ram_we=4'hF` at 0x11 with lanes {5,6,7,8} on consecutive cycles; `done` coincides with the second write.
- **Partial tail.** `coeff_num=6`, data 1..6. Required: the second write is at `base+1` with `ram_we=4'b0011`, lanes 0..1 = {5,6} and lanes 2..3 = 0.
- **Stalls and wrap.** `in_valid` toggles 1,0,0,1,...; `base_addr = 2^ADDR_WIDTH-1`, `coeff_num=8`. Required: identical data to the first case, with the second line written at address 0; `ram_we` is never asserted during stalls.
- **Zero count and ignored start.** `coeff_num=0`: `done` pulses 1 cycle after `start`, `ram_we` stays 0. A `start` asserted mid-FILL is ignored and the addresses remain unchanged.
- **Reset mid-operation.** `rst` asserted after 2 of 4 coefficients. Required: no write occurs; all outputs are 0; a subsequent `start` with `coeff_num=4` behaves as in the first case.
- **Scoreboard check.** Connect to a RAM model; after random loads (random stalls, random `coeff_num` 1..64), read back and compare against the expected image.
